// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a common-anode hex 7-segment display.
// Presents one nibble at a time to a shared decoder and registers its segments.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           scan enable; low forces digit 0, cnt 0 and a blank display
//   i_dat          4*DIGITS-bit value, digit 0 is the least significant nibble
//   i_load         strobe capturing i_dat; it reaches the display at a frame boundary
//   i_blank_lz     blank leading zero digits (digit 0 always shown)
//   o_ack          pulse when a loaded value becomes the displayed value
//   o_nib          nibble of the displayed value for the current digit
//   i_seg          decoder segments for o_nib, active-low, bit0 = a
//   o_seg, o_an    registered segments / one-hot-low anodes
//   o_frame        pulse after the last digit slot of each frame
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int GUARD  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [4*DIGITS-1:0]   i_dat,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    output logic                  o_ack,
    output logic [3:0]            o_nib,
    input  logic [6:0]            i_seg,
    output logic [6:0]            o_seg,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int W  = 4 * DIGITS;

    localparam logic [CW-1:0]     CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [W-1:0]      shadow;
    logic [W-1:0]      pending;
    logic              pend;

    logic              tick;
    logic              last;
    logic              commit;
    logic              guard_done;
    logic              blank_now;
    logic              show;
    logic [DIGITS-1:0] hi_zero;

    assign tick  = i_en && (cnt == CNT_MAX);
    assign last  = (idx == IDX_MAX);

    // Display updates only between frames while scanning, so a value
    // never appears half old / half new.  When idle, commit at once.
    assign commit = i_en ? (tick && last) : 1'b1;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_done = 1'b1;
        end else begin : g_guard
            assign guard_done = (cnt >= CW'(GUARD));
        end
    endgenerate

    // hi_zero[k]: nibbles DIGITS-1 down to k are all zero.
    always_comb begin
        logic z;
        z       = 1'b1;
        hi_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            z          = z && (shadow[4*k +: 4] == 4'h0);
            hi_zero[k] = z;
        end
    end

    assign blank_now = i_blank_lz && (idx != '0) && hi_zero[idx];
    assign show      = i_en && guard_done && !blank_now;
    assign o_nib     = shadow[{idx, 2'b00} +: 4];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= '0;
            pend    <= 1'b0;
            o_an    <= '1;
            o_seg   <= 7'h7F;
            o_ack   <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            if (!i_en) begin
                cnt <= '0;
                idx <= '0;
            end else if (tick) begin
                cnt <= '0;
                idx <= last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            o_frame <= tick && last;
            o_an    <= show ? ~(AN_ONE << idx) : '1;
            o_seg   <= show ? i_seg : 7'h7F;
            o_ack   <= 1'b0;

            // A load coinciding with the commit bypasses the holding
            // register; a later load overwrites an earlier one.
            if (commit && i_load) begin
                shadow <= i_dat;
                pend   <= 1'b0;
                o_ack  <= 1'b1;
            end else if (commit && pend) begin
                shadow <= pending;
                pend   <= 1'b0;
                o_ack  <= 1'b1;
            end else if (i_load) begin
                pending <= i_dat;
                pend    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=4, GUARD=1).
// A cycle-position reference model predicts every registered output.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int GUARD  = 1;
    localparam int FRAME  = DIV * DIGITS;

    logic        clk = 1'b0;
    logic        rst, en, load, blz;
    logic [15:0] dat;
    logic        ack, frame;
    logic [3:0]  nib, an;
    logic [6:0]  seg_in, seg;

    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          pos;
    logic [15:0] m_shadow, m_pending;
    bit          m_pend;
    logic [3:0]  e_an, e_nib;
    logic [6:0]  e_seg;
    logic        e_ack, e_frame;

    logic [16:0] obs, exp_v;
    assign obs   = {an, seg, ack, frame, nib};
    assign exp_v = {e_an, e_seg, e_ack, e_frame, e_nib};

    assign seg_in = segtab[nib];

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_dat      (dat),
        .i_load     (load),
        .i_blank_lz (blz),
        .o_ack      (ack),
        .o_nib      (nib),
        .i_seg      (seg_in),
        .o_seg      (seg),
        .o_an       (an),
        .o_frame    (frame)
    );

    always #5 clk = ~clk;

    function automatic bit lz_blank(int k, logic [15:0] v, bit b);
        if (!b || k == 0) return 1'b0;
        return (v >> (4 * k)) == 16'h0;
    endfunction

    function automatic logic [3:0] nib_of(logic [15:0] v, int k);
        return 4'((v >> (4 * k)) & 16'hF);
    endfunction

    // Predict the edge from current inputs, then advance one clock.
    task automatic cyc();
        int c, d;
        bit show, fin, commit;
        logic [3:0] one;
        one = 4'b0001;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F;
            e_ack = 1'b0; e_frame = 1'b0;
            pos = 0; m_shadow = '0;
            m_pending = '0; m_pend = 1'b0;
        end else begin
            c = pos % DIV;
            d = (pos / DIV) % DIGITS;
            show = en && c >= GUARD && !lz_blank(d, m_shadow, blz);
            fin = en && c == DIV - 1 && d == DIGITS - 1;
            e_an = show ? ~(one << d) : 4'hF;
            e_seg = show ? segtab[nib_of(m_shadow, d)] : 7'h7F;
            e_frame = fin;
            commit = en ? fin : 1'b1;
            e_ack = 1'b0;
            if (commit && load) begin
                m_shadow = dat; m_pend = 1'b0; e_ack = 1'b1;
            end else if (commit && m_pend) begin
                m_shadow = m_pending; m_pend = 1'b0; e_ack = 1'b1;
            end else if (load) begin
                m_pending = dat; m_pend = 1'b1;
            end
            pos = en ? (pos + 1) % FRAME : 0;
        end
        e_nib = nib_of(m_shadow, (pos / DIV) % DIGITS);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; blz = 1'b0; dat = '0;
        cyc(); cyc();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset got %h want %h", obs, exp_v);
        end
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_const got an=%h seg=%h ack=%b want F 7F 0", an, seg, ack);
        end
    endtask

    task automatic test_scan();
        int nfr, last_fr, bad;
        nfr = 0; last_fr = -1; bad = 0;
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL scan cyc%0d got %h want %h", i, obs, exp_v);
            end
            if (an != 4'hF && seg !== 7'b1000000) bad++;
            if (frame) begin
                if (last_fr >= 0 && i - last_fr != FRAME) bad++;
                last_fr = i; nfr++;
            end
        end
        checks++;
        if (nfr != 2 || bad != 0) begin
            failures++;
            $display("FAIL scan_frames got frames=%0d bad=%0d want 2 0", nfr, bad);
        end
    endtask

    task automatic test_load_sync();
        int got, early;
        bit fr_at_ack;
        got = -1; early = 0; fr_at_ack = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        load = 1'b1; dat = 16'h1234; cyc(); load = 1'b0;
        for (int i = 0; i < 3 * FRAME && got < 0; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL load_sync cyc%0d got %h want %h", i, obs, exp_v);
            end
            if (ack) begin got = i; fr_at_ack = frame; end
            else if (an != 4'hF && seg !== 7'h40) early++;
        end
        checks++;
        if (got < 0 || !fr_at_ack || early != 0) begin
            failures++;
            $display("FAIL load_ack got at=%0d frame=%b early=%0d want frame=1 early=0",
                     got, fr_at_ack, early);
        end
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (an == 4'b1110) begin
                checks++;
                if (seg !== 7'b0011001) begin
                    failures++;
                    $display("FAIL load_d0 got %b want 0011001", seg);
                end
            end
            if (an == 4'b0111) begin
                checks++;
                if (seg !== 7'b1111001) begin
                    failures++;
                    $display("FAIL load_d3 got %b want 1111001", seg);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        int bad, lit0;
        blz = 1'b1;
        en = 1'b0; load = 1'b1; dat = 16'h0050; cyc(); load = 1'b0;
        en = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL lz50 cyc%0d got %h want %h", i, obs, exp_v);
            end
            if (!an[3] || !an[2]) bad++;
            if (an == 4'b1101 && seg !== 7'h12) bad++;
            if (an == 4'b1110 && seg !== 7'h40) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lz50_digits got bad=%0d want 0", bad);
        end
        en = 1'b0; load = 1'b1; dat = 16'h0000; cyc(); load = 1'b0;
        en = 1'b1;
        bad = 0; lit0 = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            if (an != 4'hF && an != 4'b1110) bad++;
            if (an == 4'b1110) lit0++;
        end
        checks++;
        if (bad != 0 || lit0 == 0) begin
            failures++;
            $display("FAIL lz00 got bad=%0d lit0=%0d want 0 >0", bad, lit0);
        end
        blz = 1'b0;
    endtask

    task automatic test_bypass();
        int acks, n;
        acks = 0; n = 0;
        while (pos != 2 && n < 2 * FRAME) begin cyc(); n++; end
        load = 1'b1; dat = 16'hAAAA; cyc(); load = 1'b0;
        while (pos != FRAME - 1 && n < 4 * FRAME) begin
            cyc(); n++;
            if (ack) acks++;
        end
        load = 1'b1; dat = 16'hBBBB; cyc(); load = 1'b0;
        if (ack) acks++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            if (ack) acks++;
            checks++;
            if (obs !== exp_v || nib !== 4'hB) begin
                failures++;
                $display("FAIL bypass cyc%0d got %h nib=%h want %h nib=b",
                         i, obs, nib, exp_v);
            end
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL bypass_acks got %0d want 1", acks);
        end
    endtask

    task automatic test_disable();
        int n;
        n = 0;
        while ((pos % DIV) != 2 && n < FRAME) begin cyc(); n++; end
        en = 1'b0; cyc();
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || frame !== 1'b0) begin
            failures++;
            $display("FAIL dis_blank got an=%h seg=%h frame=%b want F 7F 0", an, seg, frame);
        end
        load = 1'b1; dat = 16'h9876; cyc(); load = 1'b0;
        checks++;
        if (ack !== 1'b1 || obs !== exp_v) begin
            failures++;
            $display("FAIL dis_ack got ack=%b obs=%h want 1 %h", ack, obs, exp_v);
        end
        cyc();
        en = 1'b1; cyc(); cyc();
        checks++;
        if (an !== 4'b1110 || seg !== 7'h02) begin
            failures++;
            $display("FAIL reenable got an=%b seg=%h want 1110 02", an, seg);
        end
    endtask

    task automatic test_reset_mid();
        int n, acks;
        n = 0; acks = 0;
        while (pos != 1 && n < 2 * FRAME) begin cyc(); n++; end
        load = 1'b1; dat = 16'h4321; cyc(); load = 1'b0;
        while ((pos / DIV) != 2 && n < 4 * FRAME) begin cyc(); n++; end
        rst = 1'b1; cyc();
        checks++;
        if ({an, seg, ack, frame} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid got an=%h seg=%h ack=%b frame=%b", an, seg, ack, frame);
        end
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc();
            if (ack) acks++;
        end
        checks++;
        if (acks != 0 || nib !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_ack got acks=%0d nib=%h want 0 0", acks, nib);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom % 150) == 0;
            if (($urandom % 40) == 0) en = ~en;
            if (($urandom % 60) == 0) blz = ~blz;
            load = ($urandom % 9) == 0;
            dat  = 16'($urandom >> (16 + $urandom_range(0, 16)));
            cyc();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random cyc%0d got %h want %h", i, obs, exp_v);
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_sync();
        test_leading_zero();
        test_bypass();
        test_disable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes a DIGITS-wide hex value onto a common-anode multi-digit 7-segment display.
- Drives one shared hex-to-7-segment decoder: presents one nibble at a time, registers the returned segment pattern and the matching active-low anode.
- Provides refresh prescaling, an anti-ghosting guard interval, optional leading-zero blanking, and a frame-synchronous load handshake so displayed values never tear mid-frame.

Parameters:
- DIGITS, 8, number of digits scanned; i_dat is 4*DIGITS bits wide; range 2..8.
- DIV, 50000, clock cycles per digit slot; DIV >= 2.
- GUARD, 16, cycles at the start of each slot with all anodes off; 0 <= GUARD < DIV.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  scan enable
- i_dat  in  4*DIGITS  value to display; nibble k = i_dat[4k+3:4k]; digit 0 is least significant
- i_load  in  1  1-cycle strobe; capture i_dat for display
- i_blank_lz  in  1  enable leading-zero blanking
- o_ack  out  1  1-cycle pulse when a loaded value becomes the displayed value
- o_nib  out  4  nibble to shared decoder, combinational from shadow[idx]
- i_seg  in  7  decoder result for o_nib; active-low, bit0 = a
- o_seg  out  7  registered segments, active-low
- o_an  out  DIGITS  registered anodes, active-low, one-hot-low
- o_frame  out  1  1-cycle pulse at each frame wrap

Behaviour:
- Reset (i_rst=1 at edge) sets:
  - cnt=0, idx=0, shadow=0, pending=0, pend=0
  - o_an=all 1s, o_seg=7'h7F, o_ack=0, o_frame=0
  - Reset has priority over all other inputs; a pending load is discarded.
- Prescaler:
  - cnt counts 0..DIV-1 while i_en=1.
  - tick = i_en && cnt==DIV-1; cnt wraps to 0 on tick.
  - On tick, idx increments; DIGITS-1 wraps to 0.
  - o_frame=1 in the cycle after a tick at idx==DIGITS-1.
- Output stage (registered; 1-cycle latency from cnt/idx):
  - show = i_en && cnt>=GUARD && !blank(idx).
  - o_an <= show ? ~(1<<idx) : all 1s.
  - o_seg <= show ? i_seg : 7'h7F.
  - o_nib = shadow nibble idx at all times, independent of show.
- Leading-zero blanking:
  - blank(k)=1 iff i_blank_lz=1, k!=0, and shadow nibbles DIGITS-1..k are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Load handshake:
  - i_load=1: pending <= i_dat, pend <= 1.
  - Several loads before a commit: the last one wins, and one o_ack is produced.
- Commit point:
  - With i_en=1: the tick at idx==DIGITS-1.
  - With i_en=0: every cycle.
- At a commit with pend=1: shadow <= pending, pend <= 0, o_ack=1 next cycle.
- At a commit with i_load=1 in the same cycle: shadow <= i_dat directly (bypass), pend <= 0, o_ack=1 next cycle.
- An i_load with no commit that cycle never produces an o_ack.
- i_en=0:
  - cnt and idx are forced to 0 and the outputs register as blank (o_an all 1s, o_seg 7'h7F).
  - Re-enabling starts at digit 0, cnt=0.
- i_en falling mid-slot: outputs blank on the next edge; no partial frame pulse.
- Widths:
  - cnt is clog2(DIV) bits, idx is clog2(DIGITS) bits.
  - No width overflow for legal parameter values.

Test Plan (DIGITS=4, DIV=4, GUARD=1):
- Reset/scan:
  - Stimulus: release reset with i_en=1, shadow=0, i_blank_lz=0.
  - Required: o_an sequence per slot is 1111 (guard), then 1110 x3, then 1101...; o_seg=7'b1000000 while shown.
  - Required: o_frame pulses every 16 cycles.
- Load sync:
  - Stimulus: i_load with i_dat=16'h1234 at cycle 5.
  - Required: o_ack exactly one cycle after the idx=3 tick; no change to digits before that.
  - Required: then digit 0 o_seg=7'b0011001 ("4"), digit 3 o_seg=7'b1111001 ("1").
- Leading-zero:
  - Stimulus: i_blank_lz=1, value 16'h0050.
  - Required: digits 3 and 2 have o_an=1111 throughout their slots; digit 1 shows "5", digit 0 shows "0".
  - Stimulus: value 16'h0000.
  - Required: only digit 0 lit.
- Bypass/last-wins:
  - Stimulus: i_load 16'hAAAA, then i_load 16'hBBBB coincident with the commit tick.
  - Required: shadow=16'hBBBB and a single o_ack.
- Disable:
  - Stimulus: drop i_en mid-slot.
  - Required: next cycle o_an=1111 and o_seg=7F.
  - Stimulus: i_load while disabled.
  - Required: o_ack the following cycle.
  - Stimulus: re-enable.
  - Required: starts at digit 0.
- Reset mid-operation:
  - Stimulus: assert i_rst with pend=1 during digit 2.
  - Required: all outputs at reset values next edge; no o_ack after release.
